ltc2308_responder: RTL and testbench
====================================

LTC2308_RESPONDER -- requirements
Module: ltc2308_responder

Interface
REQ-001 The block SHALL have parameter CONV_CYCLES, default 80, meaning conversion time in clk cycles (1.6 us at 50 MHz).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on convst/sck/sdi.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port convst, input, 1 bit: conversion start from the ADC controller.
REQ-006 The block SHALL have port sck, input, 1 bit: serial clock from the controller.
REQ-007 The block SHALL have port sdi, input, 1 bit: config bits from the controller.
REQ-008 The block SHALL have port sdo, output, 1 bit: result bits to the controller.
REQ-009 The block SHALL have port sample_in, input, 12 bits: unsigned analog stand-in for the currently selected channel.
REQ-010 The block SHALL have port channel, output, 3 bits: active channel decoded from the latched config.
REQ-011 The block SHALL have port cfg_word, output, 6 bits: latched {S/D,O/S,S1,S0,UNI,SLP}.
REQ-012 The block SHALL have port busy, output, 1 bit: high while converting.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the 12th SCK falling edge.
REQ-014 The block SHALL have port frame_abort, output, 1 bit: one-cycle pulse when a frame is cut short by convst.

Function
REQ-015 convst, sck and sdi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on synchronized values, giving a fixed input-to-detect latency of SYNC_STAGES+1 cycles.
REQ-016 The FSM SHALL have states IDLE, CONV, WAIT_LOW, SHIFT.
REQ-017 IDLE -> CONV SHALL occur on a detected convst rise: capture sample_in into result, load the counter with CONV_CYCLES-1, set busy=1.
REQ-018 In CONV, convst and sck edges SHALL be ignored; at counter==0 the FSM SHALL go to WAIT_LOW and set busy=0.
REQ-019 Capture coding SHALL be: UNI=1 -> result=sample_in; UNI=0 -> result=sample_in XOR 12'h800 (two's complement).
REQ-020 WAIT_LOW -> SHIFT SHALL occur on synchronized convst==0, with sdo=result[11] and bit counter=0; if convst is already low when CONV ends, the transition SHALL happen in the next cycle.
REQ-021 In SHIFT, on each detected sck rise with counter<6, sdi SHALL be shifted MSB-first into a 6-bit cfg shift register.
REQ-022 In SHIFT, on each detected sck fall, the counter SHALL increment and sdo SHALL present result[10-counter_old].
REQ-023 After the 12th fall: sdo=0, frame_done pulses, FSM -> IDLE.
REQ-024 cfg_word SHALL update from the shift register only when all 6 bits have been received, at frame end or at an abort with counter>=6; otherwise the previous cfg_word SHALL be kept.
REQ-025 channel SHALL equal {S1,S0,O/S} when S/D=1, and {S1,S0,1'b0} when S/D=0 (differential pair base).
REQ-026 A convst rise in SHIFT or WAIT_LOW SHALL pulse frame_abort, apply REQ-024, then behave as the IDLE->CONV transition in the same cycle.
REQ-027 With SLP=1 latched, a convst rise SHALL leave the FSM in IDLE with sdo=0 until a frame's config clears SLP; the config can still be shifted from IDLE after a convst fall (no data, sdo=0).
REQ-028 sdo SHALL be registered and glitch-free; outside SHIFT, sdo=0.

Reset
REQ-029 On reset assertion, immediately: FSM=IDLE, sdo=0, busy=0, frame_done=0, frame_abort=0, result=0, counters=0, synchronizers=0, cfg_word=6'b100010 (single-ended CH0, unipolar, awake), channel=0.
REQ-030 Reset deassertion mid-frame SHALL restart cleanly; no partial config SHALL survive.

Verification
REQ-031 Reset, sample_in=12'hA5C, convst pulse, wait > CONV_CYCLES+4, 12 SCK cycles with sdi=100010 -> sdo bits 1010_0101_1100, frame_done once, channel=0.
REQ-032 sdi=110110 (S/D=1,O/S=1,S1=0,S0=1,UNI=1,SLP=0) -> cfg_word=6'b110110, channel=3'b011 after frame_done.
REQ-033 Config UNI=0, sample_in=12'h000 -> next frame sdo=12'h800; sample_in=12'hFFF -> 12'h7FF.
REQ-034 convst rise after 3 SCK falls -> frame_abort pulse, cfg_word unchanged, busy=1 within SYNC_STAGES+2 cycles.
REQ-035 SCK toggled during CONV -> sdo stays 0, counter unchanged, next frame returns correct result.
REQ-036 Reset asserted mid-SHIFT -> sdo=0 and cfg_word=6'b100010 asynchronously.

Source files
------------

// File: rtl/ltc2308_responder.sv
// rtl/ltc2308_responder.sv - behavioural LTC2308 ADC stand-in driven by an SPI-style controller
module ltc2308_responder #(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        convst,
    input  logic        sck,
    input  logic        sdi,
    output logic        sdo,
    input  logic [11:0] sample_in,
    output logic [2:0]  channel,
    output logic [5:0]  cfg_word,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam logic [5:0] CFG_RESET = 6'b100010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT_LOW,
        ST_SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] convst_sync_q, convst_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   convst_prev_q, sck_prev_q;

    state_t         state_q, state_d;
    logic [CW-1:0]  conv_cnt_q, conv_cnt_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [11:0]    result_q, result_d;
    logic [5:0]     cfg_sr_q, cfg_sr_d;
    logic [5:0]     cfg_q, cfg_d;
    logic           sdo_q, sdo_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_abort_q, frame_abort_d;

    logic convst_s, sck_s, sdi_s;
    logic convst_rise, convst_fall, sck_rise, sck_fall;
    logic [5:0] cfg_commit;

    assign convst_s    = convst_sync_q[SYNC_STAGES-1];
    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign convst_rise = convst_s & ~convst_prev_q;
    assign convst_fall = ~convst_s & convst_prev_q;
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;

    // Config only takes effect once all six bits have been shifted in.
    assign cfg_commit = (bit_cnt_q >= 4'd6) ? cfg_sr_q : cfg_q;

    // Sample coding: unipolar straight binary, bipolar flips the MSB to two's complement.
    function automatic logic [11:0] code_sample(input logic uni, input logic [11:0] s);
        return uni ? s : (s ^ 12'h800);
    endfunction

    // Shift each asynchronous input through its synchronizer chain.
    always_comb begin
        convst_sync_d    = convst_sync_q;
        sck_sync_d       = sck_sync_q;
        sdi_sync_d       = sdi_sync_q;
        convst_sync_d[0] = convst;
        sck_sync_d[0]    = sck;
        sdi_sync_d[0]    = sdi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            convst_sync_d[i] = convst_sync_q[i-1];
            sck_sync_d[i]    = sck_sync_q[i-1];
            sdi_sync_d[i]    = sdi_sync_q[i-1];
        end
    end

    // Conversion / serial-frame state machine next-state logic.
    always_comb begin
        state_d       = state_q;
        conv_cnt_d    = conv_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        result_d      = result_q;
        cfg_sr_d      = cfg_sr_q;
        cfg_d         = cfg_q;
        sdo_d         = sdo_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (convst_rise && !cfg_q[0]) begin
                    state_d    = ST_CONV;
                    result_d   = code_sample(cfg_q[1], sample_in);
                    conv_cnt_d = CW'(CONV_CYCLES - 1);
                    busy_d     = 1'b1;
                end else if (convst_fall && cfg_q[0]) begin
                    // Asleep: still accept a config frame, but with no data behind it.
                    state_d   = ST_SHIFT;
                    result_d  = 12'h000;
                    bit_cnt_d = 4'd0;
                    cfg_sr_d  = 6'd0;
                    sdo_d     = 1'b0;
                end
            end
            ST_CONV: begin
                if (conv_cnt_q == '0) begin
                    state_d = ST_WAIT_LOW;
                    busy_d  = 1'b0;
                end else begin
                    conv_cnt_d = conv_cnt_q - 1'b1;
                end
            end
            ST_WAIT_LOW, ST_SHIFT: begin
                if (convst_rise) begin
                    frame_abort_d = 1'b1;
                    cfg_d         = cfg_commit;
                    bit_cnt_d     = 4'd0;
                    sdo_d         = 1'b0;
                    if (cfg_commit[0]) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_CONV;
                        result_d   = code_sample(cfg_commit[1], sample_in);
                        conv_cnt_d = CW'(CONV_CYCLES - 1);
                        busy_d     = 1'b1;
                    end
                end else if (state_q == ST_WAIT_LOW) begin
                    if (!convst_s) begin
                        state_d   = ST_SHIFT;
                        sdo_d     = result_q[11];
                        bit_cnt_d = 4'd0;
                        cfg_sr_d  = 6'd0;
                    end
                end else if (sck_rise) begin
                    if (bit_cnt_q < 4'd6) begin
                        cfg_sr_d = {cfg_sr_q[4:0], sdi_s};
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 4'd11) begin
                        state_d      = ST_IDLE;
                        sdo_d        = 1'b0;
                        frame_done_d = 1'b1;
                        cfg_d        = cfg_sr_q;
                        bit_cnt_d    = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sdo_d     = result_q[4'd10 - bit_cnt_q];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            convst_sync_q <= '0;
            sck_sync_q    <= '0;
            sdi_sync_q    <= '0;
            convst_prev_q <= 1'b0;
            sck_prev_q    <= 1'b0;
            state_q       <= ST_IDLE;
            conv_cnt_q    <= '0;
            bit_cnt_q     <= 4'd0;
            result_q      <= 12'h000;
            cfg_sr_q      <= 6'd0;
            cfg_q         <= CFG_RESET;
            sdo_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            convst_sync_q <= convst_sync_d;
            sck_sync_q    <= sck_sync_d;
            sdi_sync_q    <= sdi_sync_d;
            convst_prev_q <= convst_s;
            sck_prev_q    <= sck_s;
            state_q       <= state_d;
            conv_cnt_q    <= conv_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            result_q      <= result_d;
            cfg_sr_q      <= cfg_sr_d;
            cfg_q         <= cfg_d;
            sdo_q         <= sdo_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign sdo         = sdo_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign cfg_word    = cfg_q;
    assign channel     = cfg_q[5] ? {cfg_q[3], cfg_q[2], cfg_q[4]} : {cfg_q[3], cfg_q[2], 1'b0};

endmodule

// File: tb/tb_ltc2308_responder.sv
// tb/tb_ltc2308_responder.sv - directed self-checking bench for ltc2308_responder
module tb_ltc2308_responder;

    localparam int CONV = 80;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        convst, sck, sdi, sdo;
    logic [11:0] sample_in;
    logic [2:0]  channel;
    logic [5:0]  cfg_word;
    logic        busy, frame_done, frame_abort;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    ltc2308_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .convst(convst), .sck(sck), .sdi(sdi), .sdo(sdo),
        .sample_in(sample_in), .channel(channel), .cfg_word(cfg_word), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [11:0] s);
        sample_in = s;
        convst = 1'b1;
        cyc(4);
        convst = 1'b0;
        cyc(CONV + 10);
    endtask

    task automatic run_bits(input logic [5:0] cfg, input int nbits, output logic [11:0] got);
        got = 12'h000;
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < 6) ? cfg[5-i] : 1'b0;
            cyc(6);
            sck = 1'b1;
            cyc(6);
            got[11-i] = sdo;
            sck = 1'b0;
        end
        cyc(8);
    endtask

    task automatic test_reset();
        reset = 1'b1; convst = 1'b0; sck = 1'b0; sdi = 1'b0; sample_in = 12'h000;
        cyc(3);
        total++; if (sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got %b want 0", sdo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL rst_cfg got %b want 100010", cfg_word); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL rst_chan got %0d want 0", channel); end
        total++; if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            bad++; $display("FAIL rst_pulses got %b%b want 00", frame_done, frame_abort); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic_frame();
        logic [11:0] got;
        int d0;
        d0 = done_cnt;
        start_conv(12'hA5C);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'hA5C) begin bad++; $display("FAIL basic_data got %h want a5c", got); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL basic_chan got %0d want 0", channel); end
        total++; if (sdo !== 1'b0) begin bad++; $display("FAIL basic_sdo_idle got %b want 0", sdo); end
    endtask

    task automatic test_cfg_update();
        logic [11:0] got;
        start_conv(12'hA5C);
        run_bits(6'b110110, 12, got);
        total++; if (got !== 12'hA5C) begin bad++; $display("FAIL cfg_data got %h want a5c", got); end
        total++; if (cfg_word !== 6'b110110) begin bad++; $display("FAIL cfg_word got %b want 110110", cfg_word); end
        total++; if (channel !== 3'b011) begin bad++; $display("FAIL cfg_chan got %b want 011", channel); end
    endtask

    task automatic test_bipolar();
        logic [11:0] got;
        start_conv(12'h000);
        run_bits(6'b100000, 12, got);
        total++; if (got !== 12'h000) begin bad++; $display("FAIL bip_uni got %h want 000", got); end
        start_conv(12'h000);
        run_bits(6'b100000, 12, got);
        total++; if (got !== 12'h800) begin bad++; $display("FAIL bip_zero got %h want 800", got); end
        start_conv(12'hFFF);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h7FF) begin bad++; $display("FAIL bip_full got %h want 7ff", got); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL bip_cfg got %b want 100010", cfg_word); end
    endtask

    task automatic test_abort();
        logic [11:0] got;
        int a0, d0;
        a0 = abort_cnt;
        d0 = done_cnt;
        start_conv(12'h5A3);
        run_bits(6'b110110, 3, got);
        convst = 1'b1;
        cyc(SYNC + 2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got %b want 1", busy); end
        cyc(3);
        total++; if (abort_cnt - a0 !== 1) begin bad++; $display("FAIL abort_pulse got %0d want 1", abort_cnt - a0); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL abort_cfg got %b want 100010", cfg_word); end
        convst = 1'b0;
        cyc(CONV + 10);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h5A3) begin bad++; $display("FAIL abort_next got %h want 5a3", got); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_sck_in_conv();
        logic [11:0] got;
        sample_in = 12'h3C3;
        convst = 1'b1;
        cyc(4);
        convst = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL conv_busy got %b want 1", busy); end
        for (int k = 0; k < 4; k++) begin
            sck = 1'b1;
            cyc(4);
            total++; if (sdo !== 1'b0) begin bad++; $display("FAIL conv_sdo_hi%0d got %b want 0", k, sdo); end
            sck = 1'b0;
            cyc(4);
            total++; if (sdo !== 1'b0) begin bad++; $display("FAIL conv_sdo_lo%0d got %b want 0", k, sdo); end
        end
        cyc(CONV);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h3C3) begin bad++; $display("FAIL conv_next got %h want 3c3", got); end
    endtask

    task automatic test_sleep();
        logic [11:0] got;
        start_conv(12'h111);
        run_bits(6'b100011, 12, got);
        total++; if (got !== 12'h111) begin bad++; $display("FAIL slp_data got %h want 111", got); end
        total++; if (cfg_word !== 6'b100011) begin bad++; $display("FAIL slp_cfg got %b want 100011", cfg_word); end
        sample_in = 12'h0F0;
        convst = 1'b1;
        cyc(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL slp_busy got %b want 0", busy); end
        convst = 1'b0;
        cyc(10);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h000) begin bad++; $display("FAIL slp_nodata got %h want 000", got); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL slp_wake got %b want 100010", cfg_word); end
        start_conv(12'h0F0);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h0F0) begin bad++; $display("FAIL slp_after got %h want 0f0", got); end
    endtask

    task automatic test_reset_mid_shift();
        logic [11:0] got;
        start_conv(12'hFFF);
        run_bits(6'b110110, 12, got);
        total++; if (cfg_word !== 6'b110110) begin bad++; $display("FAIL rmid_pre_cfg got %b want 110110", cfg_word); end
        start_conv(12'hFFF);
        run_bits(6'b100010, 8, got);
        total++; if (sdo !== 1'b1) begin bad++; $display("FAIL rmid_pre_sdo got %b want 1", sdo); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (sdo !== 1'b0) begin bad++; $display("FAIL rmid_sdo got %b want 0", sdo); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL rmid_cfg got %b want 100010", cfg_word); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL rmid_chan got %0d want 0", channel); end
        cyc(2);
        reset = 1'b0;
        cyc(3);
        start_conv(12'h123);
        run_bits(6'b100010, 12, got);
        total++; if (got !== 12'h123) begin bad++; $display("FAIL rmid_restart got %h want 123", got); end
        total++; if (cfg_word !== 6'b100010) begin bad++; $display("FAIL rmid_restart_cfg got %b want 100010", cfg_word); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cfg_update();
        test_bipolar();
        test_abort();
        test_sck_in_conv();
        test_sleep();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
